// File: rtl/debug_cmd_pkg.sv
// debug_cmd_pkg: shared constants for the debug command unit.
// Command codes, ready byte, FSM states and latch byte counts.
package debug_cmd_pkg;

  localparam logic [7:0] CMD_DUMP_REGS   = 8'h01;
  localparam logic [7:0] CMD_DUMP_IF_ID  = 8'h02;
  localparam logic [7:0] CMD_DUMP_ID_EX  = 8'h03;
  localparam logic [7:0] CMD_DUMP_EX_MEM = 8'h04;
  localparam logic [7:0] CMD_DUMP_MEM_WB = 8'h05;
  localparam logic [7:0] CMD_LOAD        = 8'h07;
  localparam logic [7:0] CMD_CONT_MODE   = 8'h08;
  localparam logic [7:0] CMD_STEP_MODE   = 8'h09;
  localparam logic [7:0] CMD_STEP        = 8'h0A;
  localparam logic [7:0] CMD_PROG_RST    = 8'h0D;

  localparam logic [7:0] READY_BYTE = 8'h52;

  localparam int SHREG_BYTES = 17;
  localparam int SHREG_W     = SHREG_BYTES * 8;

  typedef logic [3:0] state_t;

  localparam state_t ST_IDLE       = 4'd0;
  localparam state_t ST_GET_COUNT  = 4'd1;
  localparam state_t ST_GET_WORD   = 4'd2;
  localparam state_t ST_WRITE_WORD = 4'd3;
  localparam state_t ST_DUMP_LOAD  = 4'd4;
  localparam state_t ST_DUMP_SEND  = 4'd5;
  localparam state_t ST_DUMP_WAIT  = 4'd6;
  localparam state_t ST_READY_SEND = 4'd7;
  localparam state_t ST_READY_WAIT = 4'd8;

  localparam logic [4:0] IF_ID_BYTES  = 5'd8;
  localparam logic [4:0] ID_EX_BYTES  = 5'd17;
  localparam logic [4:0] EX_MEM_BYTES = 5'd10;
  localparam logic [4:0] MEM_WB_BYTES = 5'd9;

  function automatic logic [4:0] nbytes(input int width);
    return 5'((width + 7) / 8);
  endfunction

endpackage

// File: rtl/byte_serializer.sv
// byte_serializer: shifts out up to 17 bytes LSB first over the
// uart_tx start/done handshake; done_o pulses on the last byte's done.
module byte_serializer
  import debug_cmd_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               load_i,
  input  logic [SHREG_W-1:0] data_i,
  input  logic [4:0]         count_i,
  input  logic               tx_done_i,
  output logic               tx_start_o,
  output logic [7:0]         tx_data_o,
  output logic               done_o
);

  logic [SHREG_W-1:0] shreg_q, shreg_d;
  logic [4:0]         cnt_q, cnt_d;
  logic               wait_q, wait_d;
  logic               start_q, start_d;
  logic [7:0]         data_q, data_d;

  // Start a byte when idle with bytes left; shift on done.
  always_comb begin
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    wait_d  = wait_q;
    start_d = 1'b0;
    data_d  = data_q;
    if (load_i) begin
      shreg_d = data_i;
      cnt_d   = count_i;
      wait_d  = 1'b0;
    end else if (wait_q) begin
      if (tx_done_i) begin
        wait_d  = 1'b0;
        cnt_d   = cnt_q - 5'd1;
        shreg_d = shreg_q >> 8;
      end
    end else if (cnt_q != 5'd0) begin
      start_d = 1'b1;
      data_d  = shreg_q[7:0];
      wait_d  = 1'b1;
    end
  end

  // Serializer state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      shreg_q <= '0;
      cnt_q   <= '0;
      wait_q  <= 1'b0;
      start_q <= 1'b0;
      data_q  <= '0;
    end else begin
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      wait_q  <= wait_d;
      start_q <= start_d;
      data_q  <= data_d;
    end
  end

  assign tx_start_o = start_q;
  assign tx_data_o  = data_q;
  assign done_o     = wait_q & tx_done_i & (cnt_q == 5'd1);

endmodule

// File: rtl/debug_cmd_unit.sv
// debug_cmd_unit: host byte-protocol responder for the debug UART.
// Loads imem, controls run/step, dumps registers and pipeline latches.
module debug_cmd_unit
  import debug_cmd_pkg::*;
#(
  parameter int SIZE            = 32,
  parameter int NUM_REGISTERS   = 32,
  parameter int MAX_INSTRUCTION = 64,
  parameter int ADDR_WIDTH      = $clog2(MAX_INSTRUCTION),
  parameter int IF_ID_SIZE      = 64,
  parameter int ID_EX_SIZE      = 129,
  parameter int EX_MEM_SIZE     = 78,
  parameter int MEM_WB_SIZE     = 72
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic [7:0]             i_rx_data,
  input  logic                   i_rx_valid,
  output logic [7:0]             o_tx_data,
  output logic                   o_tx_start,
  input  logic                   i_tx_done,
  output logic                   o_imem_we,
  output logic [ADDR_WIDTH-1:0]  o_imem_addr,
  output logic [SIZE-1:0]        o_imem_data,
  output logic [4:0]             o_reg_addr,
  input  logic [SIZE-1:0]        i_reg_data,
  input  logic [IF_ID_SIZE-1:0]  i_if_id,
  input  logic [ID_EX_SIZE-1:0]  i_id_ex,
  input  logic [EX_MEM_SIZE-1:0] i_ex_mem,
  input  logic [MEM_WB_SIZE-1:0] i_mem_wb,
  input  logic                   i_halt,
  output logic                   o_cpu_en,
  output logic                   o_prog_rst,
  output logic                   o_step_mode,
  output logic [3:0]             o_state
);

  localparam logic [4:0] LAST_REG = 5'(NUM_REGISTERS - 1);

  state_t                state_q, state_d;
  logic                  running_q, running_d;
  logic                  step_mode_q, step_mode_d;
  logic                  step_q, step_d;
  logic                  prog_rst_q, prog_rst_d;
  logic                  imem_we_q, imem_we_d;
  logic [ADDR_WIDTH-1:0] imem_addr_q, imem_addr_d;
  logic [SIZE-1:0]       imem_data_q, imem_data_d;
  logic [4:0]            reg_addr_q, reg_addr_d;
  logic                  dump_regs_q, dump_regs_d;
  logic [7:0]            count_q, count_d;
  logic [7:0]            word_idx_q, word_idx_d;
  logic [1:0]            byte_idx_q, byte_idx_d;
  logic [SIZE-9:0]       word_q, word_d;

  logic               ser_load;
  logic [SHREG_W-1:0] ser_data;
  logic [4:0]         ser_count;
  logic               ser_done;

  // Command decode and load/dump sequencing.
  always_comb begin
    state_d     = state_q;
    running_d   = running_q & ~i_halt;
    step_mode_d = step_mode_q;
    step_d      = 1'b0;
    prog_rst_d  = 1'b0;
    imem_we_d   = 1'b0;
    imem_addr_d = imem_addr_q;
    imem_data_d = imem_data_q;
    reg_addr_d  = reg_addr_q;
    dump_regs_d = dump_regs_q;
    count_d     = count_q;
    word_idx_d  = word_idx_q;
    byte_idx_d  = byte_idx_q;
    word_d      = word_q;
    ser_load    = 1'b0;
    ser_data    = '0;
    ser_count   = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (i_rx_valid) begin
          case (i_rx_data)
            CMD_DUMP_REGS: begin
              reg_addr_d  = '0;
              dump_regs_d = 1'b1;
              state_d     = ST_DUMP_LOAD;
            end
            CMD_DUMP_IF_ID: begin
              ser_load    = 1'b1;
              ser_data    = SHREG_W'(i_if_id);
              ser_count   = nbytes(IF_ID_SIZE);
              dump_regs_d = 1'b0;
              state_d     = ST_DUMP_SEND;
            end
            CMD_DUMP_ID_EX: begin
              ser_load    = 1'b1;
              ser_data    = SHREG_W'(i_id_ex);
              ser_count   = nbytes(ID_EX_SIZE);
              dump_regs_d = 1'b0;
              state_d     = ST_DUMP_SEND;
            end
            CMD_DUMP_EX_MEM: begin
              ser_load    = 1'b1;
              ser_data    = SHREG_W'(i_ex_mem);
              ser_count   = nbytes(EX_MEM_SIZE);
              dump_regs_d = 1'b0;
              state_d     = ST_DUMP_SEND;
            end
            CMD_DUMP_MEM_WB: begin
              ser_load    = 1'b1;
              ser_data    = SHREG_W'(i_mem_wb);
              ser_count   = nbytes(MEM_WB_SIZE);
              dump_regs_d = 1'b0;
              state_d     = ST_DUMP_SEND;
            end
            CMD_LOAD: begin
              running_d = 1'b0;
              state_d   = ST_GET_COUNT;
            end
            CMD_CONT_MODE: step_mode_d = 1'b0;
            CMD_STEP_MODE: step_mode_d = 1'b1;
            CMD_PROG_RST: begin
              prog_rst_d = 1'b1;
              running_d  = 1'b1;
            end
            CMD_STEP: begin
              if (step_mode_q && running_q) begin
                step_d = 1'b1;
              end
            end
            default: ;
          endcase
        end
      end
      ST_GET_COUNT: begin
        if (i_rx_valid) begin
          count_d    = i_rx_data;
          word_idx_d = '0;
          byte_idx_d = '0;
          if (i_rx_data == 8'd0) begin
            state_d = ST_READY_SEND;
          end else begin
            state_d = ST_GET_WORD;
          end
        end
      end
      ST_GET_WORD: begin
        if (i_rx_valid) begin
          if (byte_idx_q == 2'd3) begin
            imem_we_d   = int'(word_idx_q) < MAX_INSTRUCTION;
            imem_addr_d = ADDR_WIDTH'(word_idx_q);
            imem_data_d = {i_rx_data, word_q};
            byte_idx_d  = '0;
            state_d     = ST_WRITE_WORD;
          end else begin
            word_d     = {i_rx_data, word_q[SIZE-9:8]};
            byte_idx_d = byte_idx_q + 2'd1;
          end
        end
      end
      ST_WRITE_WORD: begin
        word_idx_d = word_idx_q + 8'd1;
        if (word_idx_q == count_q - 8'd1) begin
          state_d = ST_READY_SEND;
        end else begin
          state_d = ST_GET_WORD;
        end
      end
      ST_DUMP_LOAD: begin
        ser_load  = 1'b1;
        ser_data  = SHREG_W'(i_reg_data);
        ser_count = nbytes(SIZE);
        state_d   = ST_DUMP_SEND;
      end
      ST_DUMP_SEND: begin
        if (ser_done) begin
          if (dump_regs_q && reg_addr_q != LAST_REG) begin
            state_d = ST_DUMP_WAIT;
          end else begin
            state_d = ST_READY_SEND;
          end
        end
      end
      ST_DUMP_WAIT: begin
        reg_addr_d = reg_addr_q + 5'd1;
        state_d    = ST_DUMP_LOAD;
      end
      ST_READY_SEND: begin
        ser_load  = 1'b1;
        ser_data  = SHREG_W'(READY_BYTE);
        ser_count = 5'd1;
        state_d   = ST_READY_WAIT;
      end
      ST_READY_WAIT: begin
        if (ser_done) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control state registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= ST_IDLE;
      running_q   <= 1'b0;
      step_mode_q <= 1'b0;
      step_q      <= 1'b0;
      prog_rst_q  <= 1'b0;
      imem_we_q   <= 1'b0;
      imem_addr_q <= '0;
      imem_data_q <= '0;
      reg_addr_q  <= '0;
      dump_regs_q <= 1'b0;
      count_q     <= '0;
      word_idx_q  <= '0;
      byte_idx_q  <= '0;
      word_q      <= '0;
    end else begin
      state_q     <= state_d;
      running_q   <= running_d;
      step_mode_q <= step_mode_d;
      step_q      <= step_d;
      prog_rst_q  <= prog_rst_d;
      imem_we_q   <= imem_we_d;
      imem_addr_q <= imem_addr_d;
      imem_data_q <= imem_data_d;
      reg_addr_q  <= reg_addr_d;
      dump_regs_q <= dump_regs_d;
      count_q     <= count_d;
      word_idx_q  <= word_idx_d;
      byte_idx_q  <= byte_idx_d;
      word_q      <= word_d;
    end
  end

  byte_serializer u_ser (
    .clk_i      (i_clk),
    .rst_ni     (i_rst_n),
    .load_i     (ser_load),
    .data_i     (ser_data),
    .count_i    (ser_count),
    .tx_done_i  (i_tx_done),
    .tx_start_o (o_tx_start),
    .tx_data_o  (o_tx_data),
    .done_o     (ser_done)
  );

  assign o_imem_we   = imem_we_q;
  assign o_imem_addr = imem_addr_q;
  assign o_imem_data = imem_data_q;
  assign o_reg_addr  = reg_addr_q;
  assign o_prog_rst  = prog_rst_q;
  assign o_step_mode = step_mode_q;
  assign o_state     = state_q;
  assign o_cpu_en    = (running_q & ~step_mode_q & ~i_halt) | step_q;

endmodule

// File: doc/debug_cmd_unit.md
# debug_cmd_unit

Debug-unit command responder that sits inside `mips` between the on-chip `uart_rx`/`uart_tx` pair and the pipeline. It decodes the host byte protocol and performs the matching action: program loading into instruction memory, run-mode control, single stepping, and serial dumps of the register file and pipeline latches. Every completed load or dump ends with an ASCII 'R' (0x52) ready byte.

## Interface
- SIZE, 32, data word width
- NUM_REGISTERS, 32, register-file depth dumped by 0x01
- MAX_INSTRUCTION, 64, instruction-memory depth in words
- ADDR_WIDTH, $clog2(MAX_INSTRUCTION), instruction address width
- IF_ID_SIZE / ID_EX_SIZE / EX_MEM_SIZE / MEM_WB_SIZE, 64 / 129 / 78 / 72, latch widths
- i_clk  in  1  single clock
- i_rst_n  in  1  asynchronous, active-low reset
- i_rx_data  in  8  byte from uart_rx
- i_rx_valid  in  1  one-cycle pulse, i_rx_data valid
- o_tx_data  out  8  byte to uart_tx, stable from start until done
- o_tx_start  out  1  one-cycle start pulse
- i_tx_done  in  1  one-cycle pulse, byte fully sent
- o_imem_we / o_imem_addr / o_imem_data  out  1 / ADDR_WIDTH / SIZE  instruction write port
- o_reg_addr  out  5  register-file read address (combinational read)
- i_reg_data  in  SIZE  register-file read data
- i_if_id / i_id_ex / i_ex_mem / i_mem_wb  in  latch widths  pipeline latch contents
- i_halt  in  1  program reached end; stops continuous run
- o_cpu_en  out  1  pipeline advance enable
- o_prog_rst  out  1  one-cycle PC/pipeline reset pulse
- o_step_mode  out  1  1 = step mode, 0 = continuous
- o_state  out  4  current FSM state (debug)

## Operation
- Reset values:
  - o_tx_start=0, o_tx_data=0, o_imem_we=0, o_imem_addr=0, o_imem_data=0, o_reg_addr=0
  - o_cpu_en=0, o_prog_rst=0, o_step_mode=0
  - internal running=0; state IDLE
- Commands are accepted only in IDLE. Bytes arriving in any other state except GET_COUNT/GET_WORD are dropped. Unknown codes are ignored with no response.
- 0x01: dump NUM_REGISTERS words, each LSB first (128 bytes at default), then 'R'.
- 0x02/0x03/0x04/0x05: dump IF/ID, ID/EX, EX/MEM, MEM/WB.
  - Latch is snapshotted in the accept cycle, then sent LSB byte first, zero-padded to ceil(width/8) bytes: 8/17/10/9.
  - 'R' follows the last byte.
- 0x07: load program.
  - Clears running. Next byte N = word count; then 4N bytes, each word LSB first.
  - Word k is written to address k.
  - Words with k ≥ MAX_INSTRUCTION are consumed but not written.
  - N=0 sends 'R' immediately. 'R' is also sent after the last word.
- 0x08: o_step_mode←0. 0x09: o_step_mode←1.
- 0x0D: pulse o_prog_rst; running←1.
- 0x0A: in step mode with running=1, o_cpu_en is high for exactly one cycle. Ignored otherwise.
- o_cpu_en = running & ~o_step_mode & ~i_halt, except for the step pulse.
- i_halt clears running on the cycle after it is seen.
- FSM states: IDLE, GET_COUNT, GET_WORD, WRITE_WORD, DUMP_LOAD, DUMP_SEND, DUMP_WAIT, READY_SEND, READY_WAIT.

## Timing
- All command effects appear on the cycle after the command byte's i_rx_valid.
- o_imem_we is a single-cycle pulse on the cycle after the 4th byte of a word, with addr/data valid in that cycle.
- TX handshake:
  - o_tx_start pulses for one cycle with o_tx_data valid.
  - The unit waits for i_tx_done before the next start.
  - Next start is no earlier than 1 cycle after done.
- Register dump: o_reg_addr is set one cycle before i_reg_data is captured. The file must be read combinationally.
- i_tx_done while not waiting is ignored.
- i_rx_valid and i_tx_done in the same cycle are both honoured independently.
- Reset mid-load or mid-dump returns to IDLE immediately. No partial word is written and no 'R' is sent.

## Structure
- Package debug_cmd_pkg holds:
  - command codes
  - READY byte 0x52
  - state enum
  - per-latch byte counts
- Sub-module byte_serializer: loads up to 17-byte shift register + byte count and drives o_tx_start/o_tx_data against i_tx_done. The top FSM reuses it for dumps and 'R'.

## Test plan
- Send 0x07, 0x02, then 20 00 01 00 / 09 50 20 00 -> imem[0]=0x00010020 and imem[1]=0x00205009, each with a one-cycle we; then one 'R'.
- Preload R1=0x12345678, send 0x01 -> 129 bytes; bytes 4..7 = 78 56 34 12; last byte 0x52.
- i_id_ex = {1'b1, 128'h0...01}, send 0x03 -> 17 bytes: 01, fifteen 00, then 01; followed by 'R'.
- 0x09, 0x0D, 0x0A ×3 -> o_prog_rst pulses once; o_cpu_en high for exactly 3 isolated cycles. Then 0x08 -> o_cpu_en stays high until i_halt=1, low the cycle after.
- 0x07, N=70 with 280 bytes -> 64 writes at addresses 0..63, none beyond; 'R' after the 280th byte.
- Assert i_rst_n=0 after the 2nd data byte of a load -> state IDLE, all outputs at reset values, no write, no 'R'.
